dest_data_mux: RTL
==================

# dest_data_mux

Data-path sequencer that consumes the per-request mux sequence (pid, beat count, destination) produced alongside the request path and steers the matching AXI4-Stream beats from a single source to one of N_DESTS destination streams. Each sequence entry covers exactly one transfer; the block counts beats, generates tlast on the final beat, tags beats with the pid, and advances to the next entry with no bubble between back-to-back transfers.

## Interface
- DATA_BITS, 512, stream data width (tkeep is DATA_BITS/8)
- N_DESTS, 2, number of destination streams (1..16)
- PID_BITS, 6, pid width
- LEN_BITS, 28, beat-count field width (value = beats - 1)
- DEST_BITS, 4, destination index width (≥ clog2(N_DESTS))

- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- mux_valid  in  1  sequence entry valid
- mux_ready  out  1  sequence entry accepted
- mux_pid  in  PID_BITS  pid of the transfer
- mux_len  in  LEN_BITS  beats - 1
- mux_dest  in  DEST_BITS  destination index
- s_tvalid / s_tready  in / out  1 / 1  source handshake
- s_tdata / s_tkeep / s_tlast  in  DATA_BITS / DATA_BITS/8 / 1  source beat
- m_tvalid / m_tready  out / in  N_DESTS / N_DESTS  per-destination handshake
- m_tdata / m_tkeep  out  N_DESTS*DATA_BITS / N_DESTS*DATA_BITS/8  per-destination beat (slice i for dest i)
- m_tlast  out  N_DESTS  generated last
- m_tid  out  N_DESTS*PID_BITS  pid of current transfer
- err_last  out  1  sticky: source tlast disagreed with generated tlast
- err_dest  out  1  sticky: entry with mux_dest ≥ N_DESTS received

## Operation
- Registered state: st ∈ {IDLE, XFER}, cur_dest, cur_pid, cnt (LEN_BITS), err_last, err_dest.
- IDLE: mux_ready=1; s_tready=0; all m_tvalid=0. On mux_valid: latch pid/dest, cnt←mux_len, st←XFER; if mux_dest ≥ N_DESTS set err_dest.
- XFER, valid dest d: m_tvalid[d]=s_tvalid, s_tready=m_tready[d], m_tdata/tkeep slice d = source, m_tlast[d]=(cnt==0), m_tid slice d=cur_pid; other slices tvalid=0 (data don't-care, driven as broadcast copy).
- XFER, invalid dest: drain mode, s_tready=1, no m_tvalid asserted, beats discarded but counted.
- Beat handshake (s_tvalid & s_tready): if cnt≠0, cnt←cnt-1; if cnt==0 this is the final beat.
- mux_ready in XFER = final-beat handshake in this cycle. If mux_valid also high, next entry is latched in the same cycle and st stays XFER; else st←IDLE.
- err_last set on any beat handshake where s_tlast ≠ (cnt==0); output tlast is always the generated one, source tlast ignored for framing.
- Error flags clear only on reset.
- cnt arithmetic unsigned, LEN_BITS wide, never wraps (decrement only when ≠0).

## Timing
- Reset (aresetn low, async): st=IDLE, cnt=0, errors=0; mux_ready=0, s_tready=0, all m_tvalid=0 while reset asserted. mux_ready=1 from the first cycle after deassertion.
- Output stream path is combinational (zero latency, no internal data buffer); mux_ready in XFER depends combinationally on s_tvalid and m_tready[d].
- First entry after IDLE: entry accepted cycle N, first beat can transfer cycle N+1 (one bubble). Back-to-back entries: zero bubble.
- No combinational path from mux_* inputs to m_* outputs.
- Single-beat entry (len=0): first beat carries tlast=1.
- m_tready deasserted mid-transfer: s_tready low, cnt held; tvalid/data held stable by the source per AXI rules.
- Reset mid-transfer: current transfer abandoned, partial beats not retried.

## Test plan
- Reset: hold aresetn low 5 cycles with s_tvalid=1, mux_valid=1 -> mux_ready=0, s_tready=0, m_tvalid=0; cycle after release mux_ready=1.
- Single entry pid=3, dest=1, len=3, 4 beats, m_tready=1 -> exactly 4 beats on dest 1, tid=3, tlast only on beat 4, dest 0 tvalid never high, err_last=0.
- Back-to-back entries (dest0,len=0),(dest1,len=1),(dest0,len=2), continuous source -> 6 beats, no idle cycle after the first bubble, tlast on beats 1,3,6.
- Backpressure: len=7 to dest 1, m_tready[1] toggles 1010… -> 8 beats delivered in order, cnt holds on stall, tlast on beat 8.
- Invalid dest: mux_dest=N_DESTS, len=2 -> 3 beats drained with s_tready=1, no m_tvalid, err_dest=1 sticky, next valid entry routed normally.
- tlast mismatch: len=3, source tlast on beat 2 -> output tlast only on beat 4, err_last=1 after beat 2.

Source files
------------

// File: rtl/dest_data_mux.sv
// Steers AXI4-Stream beats from one source to one of N_DESTS destinations, following a
// sequence of (pid, beat count, dest) entries; generates tlast and tags beats with the pid.
module dest_data_mux #(
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned N_DESTS   = 2,
    parameter int unsigned PID_BITS  = 6,
    parameter int unsigned LEN_BITS  = 28,
    parameter int unsigned DEST_BITS = 4
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            mux_valid,
    output logic                            mux_ready,
    input  logic [PID_BITS-1:0]             mux_pid,
    input  logic [LEN_BITS-1:0]             mux_len,
    input  logic [DEST_BITS-1:0]            mux_dest,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    input  logic [DATA_BITS-1:0]            s_tdata,
    input  logic [DATA_BITS/8-1:0]          s_tkeep,
    input  logic                            s_tlast,
    output logic [N_DESTS-1:0]              m_tvalid,
    input  logic [N_DESTS-1:0]              m_tready,
    output logic [N_DESTS*DATA_BITS-1:0]    m_tdata,
    output logic [N_DESTS*DATA_BITS/8-1:0]  m_tkeep,
    output logic [N_DESTS-1:0]              m_tlast,
    output logic [N_DESTS*PID_BITS-1:0]     m_tid,
    output logic                            err_last,
    output logic                            err_dest
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e               st_q, st_d;
    logic [DEST_BITS-1:0] cur_dest_q, cur_dest_d;
    logic [PID_BITS-1:0]  cur_pid_q, cur_pid_d;
    logic [LEN_BITS-1:0]  cnt_q, cnt_d;
    logic                 err_last_q, err_last_d;
    logic                 err_dest_q, err_dest_d;

    logic [N_DESTS-1:0]   dest_sel;
    logic                 cur_ok;
    logic                 new_ok;
    logic                 cnt_zero;
    logic                 beat;
    logic                 final_beat;
    logic                 accept;

    function automatic logic dest_in_range(input logic [DEST_BITS-1:0] d);
        return {1'b0, d} < (DEST_BITS + 1)'(N_DESTS);
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st_q       <= StIdle;
            cur_dest_q <= '0;
            cur_pid_q  <= '0;
            cnt_q      <= '0;
            err_last_q <= 1'b0;
            err_dest_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            cur_dest_q <= cur_dest_d;
            cur_pid_q  <= cur_pid_d;
            cnt_q      <= cnt_d;
            err_last_q <= err_last_d;
            err_dest_q <= err_dest_d;
        end
    end

    // Handshake decode shared by next-state and output logic. An out-of-range dest leaves
    // dest_sel all-zero, which makes the block drain beats with no m_tvalid.
    always_comb begin
        dest_sel = '0;
        for (int i = 0; i < N_DESTS; i++) begin
            dest_sel[i] = (cur_dest_q == DEST_BITS'(i));
        end
        cur_ok     = dest_in_range(cur_dest_q);
        new_ok     = dest_in_range(mux_dest);
        cnt_zero   = (cnt_q == '0);
        s_tready   = (st_q == StXfer) && (cur_ok ? |(dest_sel & m_tready) : 1'b1);
        beat       = s_tvalid && s_tready;
        final_beat = beat && cnt_zero;
        mux_ready  = aresetn && ((st_q == StIdle) || final_beat);
        accept     = mux_valid && mux_ready;
    end

    always_comb begin
        st_d       = st_q;
        cur_dest_d = cur_dest_q;
        cur_pid_d  = cur_pid_q;
        cnt_d      = cnt_q;
        err_last_d = err_last_q;
        err_dest_d = err_dest_q;

        if (beat && (s_tlast != cnt_zero)) begin
            err_last_d = 1'b1;
        end

        if (accept) begin
            // Next entry is taken on the final beat itself so back-to-back transfers have no gap.
            st_d       = StXfer;
            cur_dest_d = mux_dest;
            cur_pid_d  = mux_pid;
            cnt_d      = mux_len;
            if (!new_ok) begin
                err_dest_d = 1'b1;
            end
        end else if (final_beat) begin
            st_d = StIdle;
        end else if (beat) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        m_tvalid = '0;
        m_tlast  = '0;
        if (st_q == StXfer) begin
            m_tvalid = dest_sel & {N_DESTS{s_tvalid}};
            m_tlast  = dest_sel & {N_DESTS{cnt_zero}};
        end
        m_tdata  = {N_DESTS{s_tdata}};
        m_tkeep  = {N_DESTS{s_tkeep}};
        m_tid    = {N_DESTS{cur_pid_q}};
        err_last = err_last_q;
        err_dest = err_dest_q;
    end

endmodule
